// File: rtl/uart_rom_loader.sv
// uart_rom_loader: receives a program image over an 8N1 UART line, writes it
// word by word into the instruction ROM write port and holds the core in
// reset until a complete, valid image has been loaded.
//
// Frame: A5, count LSB, count MSB (N words), N*4 data bytes (little-endian),
// and, when LOADER_CHECKSUM_EN is defined, a trailing byte equal to the sum
// mod 256 of all data bytes.
//
// Optional feature macro: LOADER_CHECKSUM_EN (trailing checksum byte).
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   uart_rx     in   asynchronous serial input, idle high
//   rom_we      out  one-cycle ROM write strobe
//   rom_waddr   out  ROM word address
//   rom_wdata   out  ROM write data
//   core_rst_n  out  core reset, active low (high only after a good load)
//   busy        out  frame in progress
//   load_done   out  last frame loaded OK
//   load_err    out  last frame failed
module uart_rom_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_waddr,
  output logic [DATA_WIDTH-1:0] rom_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned FULL  = CLKS_PER_BIT - 1;
  localparam int unsigned CAP   = 1 << ADDR_WIDTH;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM,
                            ST_DONE, ST_ERR} state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CSUM;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // UART receiver
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_c, frame_err_c;
  logic [7:0]       rx_byte_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    rx_byte_c    = shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // A line that is high again at mid-start was a glitch
        if (cnt_q == CNT_W'(HALF)) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(FULL)) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(FULL)) begin
          rx_state_d   = RX_IDLE;
          byte_valid_c = sync2_q;
          frame_err_c  = !sync2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Frame parser and ROM writer
  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic [15:0]           len_n;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0] rom_waddr_q, rom_waddr_d;
  logic [DATA_WIDTH-1:0] rom_wdata_q, rom_wdata_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      wcnt_q       <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      rom_we_q     <= 1'b0;
      rom_waddr_q  <= '0;
      rom_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      rom_we_q     <= rom_we_d;
      rom_waddr_q  <= rom_waddr_d;
      rom_wdata_q  <= rom_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    idx_d       = idx_q;
    word_d      = word_q;
    len_n       = {rx_byte_c, len_lo_q};
    rom_we_d    = 1'b0;
    rom_wdata_d = rom_wdata_q;
    // Address advances the cycle after each write strobe
    rom_waddr_d = rom_we_q ? rom_waddr_q + ADDR_WIDTH'(1) : rom_waddr_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (byte_valid_c && rx_byte_c == SYNC_BYTE) begin
          state_d = ST_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (byte_valid_c) begin
          len_lo_d = rx_byte_c;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (byte_valid_c) begin
          if (32'(len_n) > CAP) begin
            state_d = ST_ERR;
          end else if (len_n == 16'd0) begin
            state_d = ST_AFTER_DATA;
          end else begin
            state_d     = ST_DATA;
            len_d       = len_n;
            wcnt_d      = '0;
            idx_d       = '0;
            rom_waddr_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid_c) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + rx_byte_c;
`endif
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: word_d[7:0]   = rx_byte_c;
            2'd1: word_d[15:8]  = rx_byte_c;
            2'd2: word_d[23:16] = rx_byte_c;
            default: begin
              rom_we_d    = 1'b1;
              rom_wdata_d = DATA_WIDTH'({rx_byte_c, word_q});
              wcnt_d      = wcnt_q + 16'd1;
              if (wcnt_d == len_q) state_d = ST_AFTER_DATA;
            end
          endcase
        end
      end
      ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (byte_valid_c) state_d = (rx_byte_c == csum_q) ? ST_DONE : ST_ERR;
`else
        state_d = ST_ERR;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // A corrupted byte inside a frame aborts it; the core stays in reset
    if (frame_err_c && (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM}))
      state_d = ST_ERR;

    busy_d       = state_d inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    core_rst_n_d = (state_d == ST_DONE);
    load_done_d  = (state_d == ST_DONE);
    load_err_d   = (state_d == ST_ERR);
  end

  assign rom_we     = rom_we_q;
  assign rom_waddr  = rom_waddr_q;
  assign rom_wdata  = rom_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Testbench for uart_rom_loader: drives UART frames, predicts ROM writes and
// final status from a frame-level model, and checks writes in a monitor.
module tb_uart_rom_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 4;
  localparam int unsigned CAP = 1 << AW;

  localparam int OUT_IDLE = 0;
  localparam int OUT_DONE = 1;
  localparam int OUT_ERR  = 2;
  localparam int OUT_BUSY = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_rx;
  logic          rom_we;
  logic [AW-1:0] rom_waddr;
  logic [31:0]   rom_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  uart_rom_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] frame_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard
  logic          prev_we = 1'b0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin
    if (prev_we) begin
      check("we_single_cycle", 64'(rom_we), 64'(0));
      check("waddr_after_write", 64'(rom_waddr), 64'(AW'(last_addr + 1'b1)));
    end
    if (rom_we && !prev_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                 rom_waddr, rom_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(rom_waddr), 64'(mon_e.addr));
        check("write_data", 64'(rom_wdata), 64'(mon_e.data));
      end
      last_addr = rom_waddr;
    end
    prev_we = rom_we;
  end

  // Frame-level reference: which words land in ROM and how the frame ends.
  // fe_idx is the index of the byte sent with a bad stop bit (-1: none).
  task automatic model_frame(input logic [7:0] fr[$], input int fe_idx, output int outcome);
    int  avail, n, words;
    wr_t e;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'd0;
`endif
    avail   = (fe_idx >= 0) ? fe_idx : fr.size();
    outcome = (fe_idx >= 0) ? OUT_ERR : OUT_BUSY;
    if (avail < 3) return;
    n = int'({fr[2], fr[1]});
    if (n > int'(CAP)) begin
      outcome = OUT_ERR;
      return;
    end
    words = (avail - 3) / 4;
    if (words > n) words = n;
    for (int w = 0; w < words; w++) begin
      e.addr = AW'(w);
      e.data = {fr[3+4*w+3], fr[3+4*w+2], fr[3+4*w+1], fr[3+4*w]};
      exp_q.push_back(e);
`ifdef LOADER_CHECKSUM_EN
      for (int b = 0; b < 4; b++) sum = 8'(sum + fr[3+4*w+b]);
`endif
    end
    if (words < n) return;
`ifdef LOADER_CHECKSUM_EN
    if (avail > 3 + 4*n) outcome = (fr[3+4*n] == sum) ? OUT_DONE : OUT_ERR;
`else
    outcome = OUT_DONE;
`endif
  endtask

  // Called aligned to a falling clock edge; returns at the end of the stop bit
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_outcome(input string name, input int outcome);
    logic [3:0] exp;  // {core_rst_n, busy, load_done, load_err}
    case (outcome)
      OUT_DONE: exp = 4'b1010;
      OUT_ERR:  exp = 4'b0001;
      OUT_BUSY: exp = 4'b0100;
      default:  exp = 4'b0000;
    endcase
    check({name, "_status"}, 64'({core_rst_n, busy, load_done, load_err}), 64'(exp));
    check({name, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_frame(input string name, input logic [7:0] fr[$], input int fe_idx);
    int outcome;
    model_frame(fr, fe_idx, outcome);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], (i == fe_idx) ? 1'b0 : 1'b1);
      if (i == fe_idx) break;
    end
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    check_outcome(name, outcome);
  endtask

  task automatic build_frame(input int n, input bit bad_csum);
    logic [7:0] b;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'd0;
`endif
    frame_q = {};
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
`ifdef LOADER_CHECKSUM_EN
      sum = 8'(sum + b);
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    frame_q.push_back(bad_csum ? 8'(sum + 8'd1) : sum);
`else
    if (bad_csum) frame_q.push_back(8'hA5);
    if (bad_csum) void'(frame_q.pop_back());
`endif
  endtask

  function automatic logic [40:0] all_outputs();
    return {rom_we, rom_waddr, rom_wdata, core_rst_n, busy, load_done, load_err};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int outcome;
    bit got;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    #12;
    check("reset_outputs", 64'(all_outputs()), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // One-cycle glitch, then noise bytes before any sync byte
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (6) @(negedge clk);
    check_outcome("noise_ignored", OUT_IDLE);

    // Known good frame
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
`ifndef LOADER_CHECKSUM_EN
    void'(frame_q.pop_back());
`endif
    run_frame("good_frame", frame_q, -1);

    // Same frame with a wrong checksum byte
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
`ifndef LOADER_CHECKSUM_EN
    void'(frame_q.pop_back());
`endif
    run_frame("bad_csum", frame_q, -1);

    // One word over capacity
    frame_q = {8'hA5, 8'h11, 8'h00};
    run_frame("oversize", frame_q, -1);

    // Bad stop bit on the third byte of word 1
    build_frame(3, 1'b0);
    run_frame("framing_err", frame_q, 9);
    check("framing_err_waddr_hold", 64'(rom_waddr), 64'(1));

    // Reset in the middle of word 1
    build_frame(2, 1'b0);
    while (frame_q.size() > 9) void'(frame_q.pop_back());
    run_frame("midframe", frame_q, -1);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", 64'(all_outputs()), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Empty image
    build_frame(0, 1'b0);
    run_frame("empty_image", frame_q, -1);

    // Restart from DONE: the sync byte alone must drop the core reset
    build_frame(0, 1'b0);
    model_frame(frame_q, -1, outcome);
    send_byte(8'hA5, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      if (!core_rst_n) got = 1'b1;
      else @(negedge clk);
    end
    check("restart_core_rst_n", 64'(core_rst_n), 64'(0));
    check("restart_busy", 64'({busy, load_done, load_err}), 64'(3'b100));
    for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b1);
    repeat (6) @(negedge clk);
    check_outcome("restart_done", outcome);

    // Randomized frames, back-to-back bytes
    for (int r = 0; r < 6; r++) begin
      build_frame(int'($urandom_range(0, CAP)), ($urandom_range(0, 2) == 0));
      run_frame("rand_frame", frame_q, -1);
    end
    for (int r = 0; r < 2; r++) begin
      build_frame(int'($urandom_range(CAP + 1, 400)), 1'b0);
      while (frame_q.size() > 3) void'(frame_q.pop_back());
      run_frame("rand_oversize", frame_q, -1);
    end
    for (int r = 0; r < 3; r++) begin
      build_frame(int'($urandom_range(1, 6)), 1'b0);
      run_frame("rand_framing", frame_q, int'($urandom_range(1, frame_q.size() - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
